// File: rtl/elastic_pipeline_if.sv
// Handshake bundle for elastic_pipeline: upstream source, downstream sink,
// global enable/flush and the occupancy readback.
interface elastic_pipeline_if #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int CNT_W      = (NUM_STAGES < 1) ? 1 : $clog2(NUM_STAGES + 1)
);
  logic                            en_in;
  logic                            flush_in;
  logic [NUM_LANES*DATA_WIDTH-1:0] src_data_in;
  logic                            src_valid_in;
  logic                            src_ready_out;
  logic [NUM_LANES*DATA_WIDTH-1:0] dst_data_out;
  logic                            dst_valid_out;
  logic                            dst_ready_in;
  logic [CNT_W-1:0]                occupancy_out;

  // Driver side: produces beats, consumes the pipeline output.
  modport master (
    output en_in, flush_in, src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, dst_data_out, dst_valid_out, occupancy_out
  );

  // Pipeline side.
  modport slave (
    input  en_in, flush_in, src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, dst_data_out, dst_valid_out, occupancy_out
  );
endinterface

// File: rtl/elastic_pipeline.sv
// Multi-lane elastic delay pipeline: per-slot valid/ready, bubble
// collapsing, synchronous flush and a registered occupancy count.
module elastic_pipeline #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int BYPASS     = 0,
  parameter int CNT_W      = (NUM_STAGES < 1) ? 1 : $clog2(NUM_STAGES + 1)
) (
  input logic               clk,
  input logic               arst_n,
  elastic_pipeline_if.slave bus
);

  localparam int W = NUM_LANES * DATA_WIDTH;

  generate
    if (BYPASS != 0 || NUM_STAGES == 0) begin : g_pass
      assign bus.dst_data_out  = bus.src_data_in;
      assign bus.dst_valid_out = bus.src_valid_in & bus.en_in;
      assign bus.src_ready_out = bus.dst_ready_in & bus.en_in;
      assign bus.occupancy_out = '0;
    end else begin : g_pipe
      localparam int N = NUM_STAGES;

      logic [N-1:0]     v_q, v_d, adv;
      logic [W-1:0]     d_q [N];
      logic [W-1:0]     d_d [N];
      logic [CNT_W-1:0] occ_q, occ_d;
      logic             live, up, dn;

      assign live = bus.en_in & ~bus.flush_in;

      // Ready chain, evaluated from the output slot back to the input slot;
      // a scalar carry avoids a self-referencing vector in one block.
      always_comb begin
        logic a;
        adv    = '0;
        a      = live & (~v_q[N-1] | bus.dst_ready_in);
        adv[N-1] = a;
        for (int unsigned i = 1; i < N; i++) begin
          a = live & (~v_q[N-1-i] | a);
          adv[N-1-i] = a;
        end
      end

      // Slot next-state: advancing slots take the upstream neighbour, data
      // only follows a valid beat so empty slots keep stable contents.
      always_comb begin
        v_d = v_q;
        for (int unsigned k = 0; k < N; k++) d_d[k] = d_q[k];
        if (adv[0]) begin
          v_d[0] = bus.src_valid_in;
          if (bus.src_valid_in) d_d[0] = bus.src_data_in;
        end
        for (int unsigned k = 1; k < N; k++) begin
          if (adv[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) d_d[k] = d_q[k-1];
          end
        end
        if (bus.flush_in) v_d = '0;
      end

      assign up = bus.src_valid_in & adv[0];
      assign dn = bus.dst_valid_out & bus.dst_ready_in;

      // Occupancy follows accepted/released beats; flush empties it.
      always_comb begin
        occ_d = occ_q;
        if (bus.flush_in)  occ_d = '0;
        else if (up && !dn) occ_d = occ_q + CNT_W'(1);
        else if (dn && !up) occ_d = occ_q - CNT_W'(1);
      end

      // State registers with asynchronous clear.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          v_q   <= '0;
          occ_q <= '0;
          for (int unsigned k = 0; k < N; k++) d_q[k] <= '0;
        end else begin
          v_q   <= v_d;
          occ_q <= occ_d;
          for (int unsigned k = 0; k < N; k++) d_q[k] <= d_d[k];
        end
      end

      assign bus.src_ready_out = adv[0];
      assign bus.dst_valid_out = v_q[N-1] & bus.en_in;
      assign bus.dst_data_out  = d_q[N-1];
      assign bus.occupancy_out = occ_q;
    end
  endgenerate

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: a 4-slot build and a bypass build driven
// with the same stimulus, compared against a beat-list reference model.
module tb_elastic_pipeline;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NL = 2;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  elastic_pipeline_if #(.NUM_STAGES(N), .DATA_WIDTH(DW), .NUM_LANES(NL)) pif ();
  elastic_pipeline_if #(.NUM_STAGES(N), .DATA_WIDTH(DW), .NUM_LANES(NL)) bif ();

  assign bif.en_in        = pif.en_in;
  assign bif.flush_in     = pif.flush_in;
  assign bif.src_data_in  = pif.src_data_in;
  assign bif.src_valid_in = pif.src_valid_in;
  assign bif.dst_ready_in = pif.dst_ready_in;

  elastic_pipeline #(.NUM_STAGES(N), .DATA_WIDTH(DW), .NUM_LANES(NL), .BYPASS(0)) u_pipe (
    .clk(clk), .arst_n(arst_n), .bus(pif));
  elastic_pipeline #(.NUM_STAGES(N), .DATA_WIDTH(DW), .NUM_LANES(NL), .BYPASS(1)) u_byp (
    .clk(clk), .arst_n(arst_n), .bus(bif));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: list of in-flight beats, oldest first, each with its
  // slot position. A beat moves forward if the slot ahead is free or the
  // beat occupying it moves (or leaves) this cycle.
  int          pos_q[$];
  logic [31:0] dat_q[$];

  task automatic model_clear();
    pos_q.delete();
    dat_q.delete();
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // advance the model across the rising edge.
  task automatic cycle(input bit en, input bit fl, input bit sv,
                       input logic [31:0] sd, input bit dr);
    bit mv[N];
    bit live, exp_rdy, exp_vld, leave;
    int n;
    pif.en_in = en; pif.flush_in = fl; pif.src_valid_in = sv;
    pif.src_data_in = sd; pif.dst_ready_in = dr;
    #1;
    n    = pos_q.size();
    live = en && !fl;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    if (live) begin
      for (int i = 0; i < n; i++) begin
        if (i == 0) mv[i] = (pos_q[0] == N-1) ? dr : 1'b1;
        else        mv[i] = (pos_q[i-1] > pos_q[i] + 1) || mv[i-1];
      end
    end
    exp_rdy = live && !(n > 0 && pos_q[n-1] == 0 && !mv[n-1]);
    exp_vld = en && n > 0 && pos_q[0] == N-1;
    chk("src_ready", 64'(pif.src_ready_out), 64'(exp_rdy));
    chk("dst_valid", 64'(pif.dst_valid_out), 64'(exp_vld));
    chk("occupancy", 64'(pif.occupancy_out), 64'(n));
    if (exp_vld) chk("dst_data", 64'(pif.dst_data_out), 64'(dat_q[0]));
    chk("byp_data",  64'(bif.dst_data_out),  64'(sd));
    chk("byp_valid", 64'(bif.dst_valid_out), 64'(sv && en));
    chk("byp_ready", 64'(bif.src_ready_out), 64'(dr && en));
    chk("byp_occ",   64'(bif.occupancy_out), 64'(0));
    @(posedge clk);
    if (fl) model_clear();
    else if (live) begin
      leave = n > 0 && pos_q[0] == N-1 && mv[0];
      for (int i = 0; i < n; i++) pos_q[i] = pos_q[i] + int'(mv[i]);
      if (leave) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (sv && exp_rdy) begin
        pos_q.push_back(0);
        dat_q.push_back(sd);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(pif.dst_valid_out), 64'(0));
    chk({tag, "_data"},  64'(pif.dst_data_out),  64'(0));
    chk({tag, "_occ"},   64'(pif.occupancy_out), 64'(0));
  endtask

  initial begin
    arst_n = 1'b0;
    pif.en_in = 1'b1; pif.flush_in = 1'b0; pif.src_valid_in = 1'b0;
    pif.src_data_in = '0; pif.dst_ready_in = 1'b0;
    model_clear();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("reset_ready", 64'(pif.src_ready_out), 64'(1));
    @(negedge clk);

    // Streaming with a counting pattern.
    for (int i = 0; i < 20; i++)
      cycle(1, 0, 1, {16'(i + 1), 16'(i)}, 1);
    // Back-pressure fill then release.
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 32'hB000_0000 + 32'(i), 0);
    chk("full_occ", 64'(pif.occupancy_out), 64'(N));
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 32'hB100_0000 + 32'(i), 1);
    // Bubble collapse: A, two idles, B, all stalled.
    cycle(1, 1, 0, '0, 0);
    cycle(1, 0, 1, 32'hAAAA_0001, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 1, 32'hBBBB_0002, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, '0, 0);
    chk("bubble_occ", 64'(pif.occupancy_out), 64'(2));
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, '0, 1);
    // Flush at occupancy 3 with a beat offered.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 32'hF000_0000 + 32'(i), 0);
    cycle(1, 1, 1, 32'hDEAD_BEEF, 1);
    chk("flush_occ", 64'(pif.occupancy_out), 64'(0));
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, '0, 1);
    // Enable freeze mid-stream.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 32'hE000_0000 + 32'(i), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'hE100_0000 + 32'(i), 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 32'hE200_0000 + 32'(i), 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    // Reset while full.
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 32'hC000_0000 + 32'(i), 0);
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1, 0, 1, 32'hD000_0000 + 32'(i), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
# elastic_pipeline

Parametrised multi-lane delay pipeline with per-stage valid/ready flow control, bubble collapsing, synchronous flush and an occupancy count. It is the successor to the fixed-latency valid/data delay line in the FFT datapath. It is used wherever a stage must be retimed but the downstream consumer, such as a butterfly, a twiddle ROM arbiter or an output FIFO, can apply back-pressure. Each stage is a register slot that holds one beat of NUM_LANES × DATA_WIDTH bits.

## Interface
- NUM_STAGES, 4: number of register slots; 0 selects pass-through.
- DATA_WIDTH, 16: bits per lane (signed sample).
- NUM_LANES, 2: parallel lanes per beat (e.g. 2 = I/Q).
- BYPASS, 0: 1 forces pass-through regardless of NUM_STAGES.
- CNT_W, $clog2(NUM_STAGES+1): derived width of occupancy; minimum 1.

- clk  in  1  single clock; all state changes on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- en_in  in  1  global enable; when low, the pipeline is frozen.
- flush_in  in  1  synchronous flush; invalidates all slots.
- src_data_in  in  NUM_LANES*DATA_WIDTH  packed beat; lane 0 occupies bits [DATA_WIDTH-1:0].
- src_valid_in  in  1  upstream beat valid.
- src_ready_out  out  1  pipeline can accept a beat this cycle.
- dst_data_out  out  NUM_LANES*DATA_WIDTH  beat in the last slot.
- dst_valid_out  out  1  last slot valid and en_in high.
- dst_ready_in  in  1  downstream accepts the beat.
- occupancy_out  out  CNT_W  number of valid slots.

## Operation
- Slots are numbered 0 (input side) to N-1 (output side). Each slot k holds v[k] and d[k].
- Advance terms:
  - adv[N-1] = en_in & ~flush_in & (~v[N-1] | dst_ready_in).
  - adv[k] = en_in & ~flush_in & (~v[k] | adv[k+1]).
- src_ready_out = adv[0].
- When adv[k] is true:
  - slot k loads from slot k-1: v[k] <= v[k-1], d[k] <= d[k-1].
  - Slot 0 loads src_valid_in and src_data_in.
  - d loads only when the incoming valid is 1; data of empty slots is don't-care but stable.
- When adv[k] is false, slot k holds.
- Bubbles collapse: an empty slot accepts a beat even while a downstream slot is stalled.
- Transfers:
  - An upstream transfer is src_valid_in & src_ready_out.
  - A downstream transfer is dst_valid_out & dst_ready_in.
- The ready chain is combinational across all slots. Timing closure for NUM_STAGES > 8 is the integrator's responsibility.
- Flush:
  - In the cycle flush_in is high, every v[k] <= 0 and occupancy <= 0.
  - src_ready_out = 0 and no beat is accepted.
  - dst_valid_out is still shown, and a downstream transfer in that cycle is legal. The beat is dropped from the pipeline either way.
  - Flush has priority over en_in.
- en_in low: no slot updates, src_ready_out = 0, dst_valid_out = 0. occupancy_out holds.
- Occupancy is a registered counter:
  - +1 on an upstream transfer, -1 on a downstream transfer, unchanged when both occur.
  - It must always equal the popcount of v.
- Data is passed through unmodified; there is no arithmetic on lanes.
- Pass-through (BYPASS = 1 or NUM_STAGES = 0):
  - dst_data_out = src_data_in, dst_valid_out = src_valid_in & en_in.
  - src_ready_out = dst_ready_in & en_in.
  - occupancy_out = 0; flush_in is ignored; no registers.

## Timing
- Reset (arst_n low, asynchronous): all v = 0, all d = 0, occupancy_out = 0, dst_valid_out = 0, dst_data_out = 0. src_ready_out = 1 once arst_n is high and en_in = 1.
- Latency: a beat accepted at edge t appears on dst_valid_out after edge t+N-1, i.e. N cycles from accept to first possible consume with no stall.
- Throughput: 1 beat per cycle with dst_ready_in held high.
- Full (occupancy = N) with dst_ready_in = 0: src_ready_out = 0.
- Full with dst_ready_in = 1: simultaneous accept and release; occupancy stays N.
- Reset asserted mid-stream: all in-flight beats are lost immediately, with no partial outputs after release.

## Test plan
- Streaming: N=4, 2 lanes, src_valid_in=1 every cycle with data 0x0001_0000, 0x0002_0001, … and dst_ready_in=1. Expected: the same sequence on dst_data_out starting 4 cycles after the first accept, with no gaps, and occupancy_out steady at 4.
- Back-pressure fill: hold dst_ready_in=0 and push 6 beats. Expected: exactly 4 beats accepted, src_ready_out low after the 4th, occupancy 4. Then release dst_ready_in. Expected: beats drain in order and the remaining 2 are accepted.
- Bubble collapse: push beats A, idle for 2 cycles, then B, with dst_ready_in=0. Expected: occupancy 2 and slots N-1, N-2 holding A and B. On release, A then B come out back-to-back.
- Flush: with occupancy 3, pulse flush_in for one cycle with src_valid_in=1. Expected: src_ready_out=0 in that cycle, occupancy 0 on the next cycle, and no stale beat ever appears.
- en_in freeze: deassert en_in for 3 cycles mid-stream. Expected: dst_valid_out=0 and src_ready_out=0, and all slot contents are unchanged. On re-enable the stream resumes with no loss or duplication.
- Reset and bypass:
  - Assert arst_n low while full. Expected: all outputs 0 immediately.
  - BYPASS=1 build. Expected: dst mirrors src combinationally and src_ready_out equals dst_ready_in.
